// File: rtl/an_scan_pkg.sv
// Shared constants and the round-robin digit search used by the anode scan controller.
package an_scan_pkg;

    // Largest supported display, and the default geometry of the block.
    localparam int N_DIGITS_MAX    = 16;
    localparam int N_DIGITS_DEF    = 8;
    localparam int REFRESH_DIV_DEF = 100000;

    localparam int DIG_IDX_W = $clog2(N_DIGITS_DEF);
    localparam int SLOT_W    = $clog2(REFRESH_DIV_DEF);

    // All anodes released (active-low drive), sliced down to N_DIGITS by users.
    localparam logic [N_DIGITS_MAX-1:0] AN_OFF = '1;

    // Returns the first set mask bit after cur, searching cur+1, cur+2, ...
    // with wrap at n. The current digit itself is the last candidate, so a
    // single enabled digit finds itself. Returns -1 when the mask is empty.
    function automatic int next_enabled(input logic [N_DIGITS_MAX-1:0] mask,
                                        input int cur,
                                        input int n);
        int p;
        int found;
        found = -1;
        for (int k = 1; k <= N_DIGITS_MAX; k++) begin
            p = cur + k;
            if (p >= n) begin
                p = p - n;
            end
            if (k <= n && found < 0 && mask[p[3:0]]) begin
                found = p;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/an_scan_ctrl_if.sv
// Control/status bundle between a display host and the anode scan controller.
interface an_scan_ctrl_if #(
    parameter int N_DIGITS = 8,
    parameter int BRIGHT_W = 3
);
    localparam int IDX_W = $clog2(N_DIGITS);

    logic                en;
    logic [N_DIGITS-1:0] en_mask;
    logic [N_DIGITS-1:0] blink_mask;
    logic [BRIGHT_W-1:0] bright;
    logic [N_DIGITS-1:0] an_out;
    logic [IDX_W-1:0]    dig_idx;
    logic                frame_start;

    // Host side: sets the scan configuration, observes anode/digit status.
    modport master (
        output en, en_mask, blink_mask, bright,
        input  an_out, dig_idx, frame_start
    );

    // Controller side.
    modport slave (
        input  en, en_mask, blink_mask, bright,
        output an_out, dig_idx, frame_start
    );

endinterface

// File: rtl/next_digit_sel.sv
// Combinational round-robin finder: next enabled digit after cur_idx.
module next_digit_sel
    import an_scan_pkg::*;
#(
    parameter int N_DIGITS = 8
) (
    input  logic [N_DIGITS-1:0]         en_mask,
    input  logic [$clog2(N_DIGITS)-1:0] cur_idx,
    output logic [$clog2(N_DIGITS)-1:0] nxt_idx,
    output logic                        wrapped,
    output logic                        none
);
    localparam int IDX_W = $clog2(N_DIGITS);

    int found;

    // Search, then flag a wrap when the new index is not past the old one.
    always_comb begin
        found   = next_enabled(N_DIGITS_MAX'(en_mask), int'(cur_idx), N_DIGITS);
        none    = (found < 0);
        wrapped = !none && (found <= int'(cur_idx));
        nxt_idx = cur_idx;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (found == i) begin
                nxt_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/an_scan_ctrl.sv
// Self-timed anode scan controller for multiplexed 7-segment displays:
// slot timing, anti-ghost blanking, PWM brightness and per-digit blink.
module an_scan_ctrl
    import an_scan_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYC    = 16,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    an_scan_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Wide enough for (REFRESH_DIV-BLANK_CYC)*(bright+1) without truncation.
    localparam int ON_W  = CNT_W + BRIGHT_W + 1;

    localparam logic [CNT_W-1:0]    SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0]    FRAME_LAST = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [ON_W-1:0]     ACTIVE_CYC = ON_W'(REFRESH_DIV - BLANK_CYC);
    localparam logic [ON_W-1:0]     BLANK_LEN  = ON_W'(BLANK_CYC);
    localparam logic [N_DIGITS-1:0] AN_ALL_OFF = AN_OFF[N_DIGITS-1:0];

    logic [CNT_W-1:0]    slot_cnt_reg,    slot_cnt_next;
    logic [IDX_W-1:0]    dig_idx_reg,     dig_idx_next;
    logic [FRM_W-1:0]    frame_cnt_reg,   frame_cnt_next;
    logic                blink_phase_reg, blink_phase_next;
    logic                frame_start_reg, frame_start_next;
    logic [N_DIGITS-1:0] an_out_reg,      an_out_next;

    logic [IDX_W-1:0]    sel_idx;
    logic                sel_wrapped;
    logic                sel_none;

    logic [ON_W-1:0]     on_time;
    logic [ON_W-1:0]     slot_ext;
    logic                in_window;
    logic                lit;

    next_digit_sel #(
        .N_DIGITS (N_DIGITS)
    ) u_next_digit_sel (
        .en_mask (bus.en_mask),
        .cur_idx (dig_idx_reg),
        .nxt_idx (sel_idx),
        .wrapped (sel_wrapped),
        .none    (sel_none)
    );

    // PWM window: dark blanking lead-in, then on_time lit cycles; masks act live.
    always_comb begin
        on_time   = (ACTIVE_CYC * (ON_W'(bus.bright) + ON_W'(1))) >> BRIGHT_W;
        slot_ext  = ON_W'(slot_cnt_reg);
        in_window = (slot_ext >= BLANK_LEN) && ((slot_ext - BLANK_LEN) < on_time);
        lit       = bus.en && bus.en_mask[dig_idx_reg] && in_window
                    && !(blink_phase_reg && bus.blink_mask[dig_idx_reg]);
    end

    // One anode per digit; only the slot owner can be pulled low.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_anode
            assign an_out_next[gi] = !(lit && (dig_idx_reg == IDX_W'(gi)));
        end
    endgenerate

    // Slot/frame counters: advance the digit at slot wrap, count frames for blink.
    always_comb begin
        slot_cnt_next    = slot_cnt_reg;
        dig_idx_next     = dig_idx_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;
        frame_start_next = 1'b0;
        if (bus.en) begin
            if (slot_cnt_reg == SLOT_LAST) begin
                slot_cnt_next = '0;
                if (!sel_none) begin
                    dig_idx_next = sel_idx;
                    if (sel_wrapped) begin
                        frame_start_next = 1'b1;
                        if (frame_cnt_reg == FRAME_LAST) begin
                            frame_cnt_next   = '0;
                            blink_phase_next = !blink_phase_reg;
                        end else begin
                            frame_cnt_next = frame_cnt_reg + FRM_W'(1);
                        end
                    end
                end
            end else begin
                slot_cnt_next = slot_cnt_reg + CNT_W'(1);
            end
        end
    end

    // State and output registers; reset releases every anode immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_reg    <= '0;
            dig_idx_reg     <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            frame_start_reg <= 1'b0;
            an_out_reg      <= AN_ALL_OFF;
        end else begin
            slot_cnt_reg    <= slot_cnt_next;
            dig_idx_reg     <= dig_idx_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
            frame_start_reg <= frame_start_next;
            an_out_reg      <= an_out_next;
        end
    end

    assign bus.an_out      = an_out_reg;
    assign bus.dig_idx     = dig_idx_reg;
    assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_an_scan_ctrl.sv
// Scoreboard bench for an_scan_ctrl with a small 4-digit geometry.
module tb_an_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BW = 2;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    an_scan_ctrl_if #(.N_DIGITS(ND), .BRIGHT_W(BW)) bus ();

    an_scan_ctrl #(
        .N_DIGITS     (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYC    (BC),
        .BRIGHT_W     (BW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [1:0] idx;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference scan state (value the DUT holds before the next edge).
    int m_slot, m_idx, m_frame;
    bit m_phase;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        m_slot  = 0;
        m_idx   = 0;
        m_frame = 0;
        m_phase = 1'b0;
        sb_q.delete();
    endtask

    // Predict the next registered outputs, clock once, compare against the queue head.
    task automatic step();
        exp_t e;
        int   on_t;
        int   p;
        int   nxt;
        bit   lit_m;
        on_t  = ((RD - BC) * (int'(bus.bright) + 1)) >> BW;
        lit_m = bus.en && bus.en_mask[m_idx[1:0]] && (m_slot >= BC) && ((m_slot - BC) < on_t)
                && !(m_phase && bus.blink_mask[m_idx[1:0]]);
        e.an = 4'b1111;
        if (lit_m) e.an[m_idx[1:0]] = 1'b0;
        e.fs = 1'b0;
        if (bus.en) begin
            if (m_slot == RD - 1) begin
                m_slot = 0;
                nxt = -1;
                for (int k = 1; k <= ND; k++) begin
                    p = (m_idx + k) % ND;
                    if (nxt < 0 && bus.en_mask[p[1:0]]) nxt = p;
                end
                if (nxt >= 0) begin
                    if (nxt <= m_idx) begin
                        e.fs = 1'b1;
                        m_frame++;
                        if (m_frame == BF) begin
                            m_frame = 0;
                            m_phase = !m_phase;
                        end
                    end
                    m_idx = nxt;
                end
            end else begin
                m_slot++;
            end
        end
        e.idx = m_idx[1:0];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check_eq("an_out", 32'(bus.an_out), 32'(e.an));
        check_eq("dig_idx", 32'(bus.dig_idx), 32'(e.idx));
        check_eq("frame_start", 32'(bus.frame_start), 32'(e.fs));
        $display("txn %0d en=%b mask=%b br=%0d an=%b idx=%0d fs=%b", cyc, bus.en, bus.en_mask,
                 bus.bright, bus.an_out, bus.dig_idx, bus.frame_start);
    endtask

    int lit0[8];
    int lit1[8];
    int frame;
    int cnt;
    int bad;
    logic [1:0] held_idx;
    logic [3:0] held_an;

    initial begin
        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.en_mask    = 4'b1111;
        bus.blink_mask = 4'b0000;
        bus.bright     = 2'd3;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_an_out", 32'(bus.an_out), 32'hF);
        check_eq("rst_dig_idx", 32'(bus.dig_idx), 32'h0);
        check_eq("rst_frame_start", 32'(bus.frame_start), 32'h0);

        // Full scan with digit 1 blinking: six frames.
        bus.en         = 1'b1;
        bus.blink_mask = 4'b0010;
        rst_n          = 1'b1;
        frame = 0;
        for (int i = 0; i < 8; i++) begin
            lit0[i] = 0;
            lit1[i] = 0;
        end
        for (int i = 0; i < 6 * ND * RD; i++) begin
            step();
            if (frame < 8 && bus.an_out == 4'b1110) lit0[frame]++;
            if (frame < 8 && bus.an_out == 4'b1101) lit1[frame]++;
            if (bus.frame_start) frame++;
        end
        check_eq("frames_seen", 32'(frame), 32'd6);
        for (int f = 0; f < 6; f++) begin
            check_eq("digit0_lit_per_frame", 32'(lit0[f]), 32'd6);
            check_eq("digit1_blink_lit", 32'(lit1[f]), (f == 2 || f == 3) ? 32'd0 : 32'd6);
        end
        bus.blink_mask = 4'b0000;

        // Sparse mask: only digits 0 and 2, wrap on each 2->0.
        bus.en_mask = 4'b0101;
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (bus.frame_start) cnt++;
            if (bus.dig_idx == 2'd1 || bus.dig_idx == 2'd3) bad++;
        end
        check_eq("sparse_frame_pulses", 32'(cnt), 32'd3);
        check_eq("sparse_bad_idx", 32'(bad), 32'd0);

        // Empty mask: dark, index holds, no frame pulses.
        bus.en_mask = 4'b0000;
        held_idx = bus.dig_idx;
        cnt = 0;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (bus.an_out != 4'b1111) cnt++;
            if (bus.frame_start || bus.dig_idx != held_idx) bad++;
        end
        check_eq("empty_mask_lit", 32'(cnt), 32'd0);
        check_eq("empty_mask_hold", 32'(bad), 32'd0);

        // Brightness: 3 lit cycles per slot at bright=1, 1 at bright=0.
        bus.en_mask = 4'b1111;
        bus.bright  = 2'd1;
        for (int g = 0; g < 16 && m_slot != 0; g++) step();
        cnt = 0;
        for (int i = 0; i < ND * RD; i++) begin
            step();
            if (bus.an_out != 4'b1111) cnt++;
        end
        check_eq("bright1_lit_frame", 32'(cnt), 32'd12);
        bus.bright = 2'd0;
        cnt = 0;
        for (int i = 0; i < ND * RD; i++) begin
            step();
            if (bus.an_out != 4'b1111) cnt++;
        end
        check_eq("bright0_lit_frame", 32'(cnt), 32'd4);

        // Freeze at slot position 4, hold 20 cycles, then resume the same slot.
        bus.bright = 2'd3;
        for (int g = 0; g < 16 && m_slot != 4; g++) step();
        bus.en = 1'b0;
        held_idx = bus.dig_idx;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.an_out != 4'b1111 || bus.dig_idx != held_idx) bad++;
        end
        check_eq("freeze_hold", 32'(bad), 32'd0);
        bus.en = 1'b1;
        held_an = 4'b1111;
        held_an[held_idx] = 1'b0;
        cnt = 0;
        for (int i = 0; i < RD; i++) begin
            step();
            if (bus.an_out == held_an) cnt++;
        end
        check_eq("resume_remaining_lit", 32'(cnt), 32'd4);
        for (int i = 0; i < 16; i++) step();

        // Asynchronous reset while a digit is lit.
        for (int g = 0; g < 40 && bus.an_out == 4'b1111; g++) step();
        check_eq("lit_before_reset", 32'(bus.an_out != 4'b1111), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_an_out", 32'(bus.an_out), 32'hF);
        check_eq("async_rst_dig_idx", 32'(bus.dig_idx), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_held_an_out", 32'(bus.an_out), 32'hF);
        #2;
        rst_n = 1'b1;
        step();
        step();
        check_eq("post_rst_dark", 32'(bus.an_out), 32'hF);
        step();
        check_eq("post_rst_lit_cycle3", 32'(bus.an_out), 32'hE);
        for (int i = 0; i < 12; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
